// File: rtl/dphy_pkg.sv
// -----------------------------------------------------------------------------
// dphy_pkg
// Shared definitions for the D-PHY HS transmit path.
//   lane_state_e   : externally meaningful lane states (IDLE .. LP_EXIT)
//   timed_phase_e  : sub-phase inside a timer-driven state
//   seq_state_t    : complete sequencer state register (lane state + phase)
//   SYNC_BYTE      : HS leader sync pattern sent after HS-ZERO
//   LP11/LP01/LP00 : low-power line levels, packed as {dp, dn}
// -----------------------------------------------------------------------------
package dphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LP_RQST   = 3'd1,
        ST_LP_BRIDGE = 3'd2,
        ST_HS_ZERO   = 3'd3,
        ST_HS_SYNC   = 3'd4,
        ST_HS_DATA   = 3'd5,
        ST_HS_TRAIL  = 3'd6,
        ST_LP_EXIT   = 3'd7
    } lane_state_e;

    // A timed state spends one cycle with the timer held off (PH_FIRST),
    // then waits for the arming pulse (PH_ARM), then for the terminal
    // pulse (PH_RUN). Untimed states always sit in PH_FIRST.
    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_ARM   = 2'd1,
        PH_RUN   = 2'd2
    } timed_phase_e;

    typedef struct packed {
        lane_state_e  st;
        timed_phase_e ph;
    } seq_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    function automatic logic is_timed(input lane_state_e s);
        return s inside {ST_LP_RQST, ST_LP_BRIDGE, ST_HS_ZERO, ST_HS_TRAIL, ST_LP_EXIT};
    endfunction

    // Where a timed state goes once its terminal pulse arrives.
    function automatic lane_state_e timed_successor(input lane_state_e s);
        lane_state_e nxt;
        nxt = ST_IDLE;
        case (s)
            ST_LP_RQST:   nxt = ST_LP_BRIDGE;
            ST_LP_BRIDGE: nxt = ST_HS_ZERO;
            ST_HS_ZERO:   nxt = ST_HS_SYNC;
            ST_HS_TRAIL:  nxt = ST_LP_EXIT;
            default:      nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dphy_hs_tx_sequencer.sv
// -----------------------------------------------------------------------------
// dphy_hs_tx_sequencer
// Sequences one D-PHY lane through a complete HS burst:
//   LP-11 -> LP-01 -> LP-00 -> HS-ZERO -> SYNC -> payload -> HS-TRAIL -> LP-11
// Timed states are paced by an external 6-bit reload timer (sibling instance).
//
// Parameters : T_LPX, T_HS_PREPARE, T_HS_ZERO, T_HS_TRAIL, T_HS_EXIT
//              (timer reload values for the five timed states)
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   hs_req        : start one burst (only looked at in IDLE)
//   tx_data/valid : payload byte stream; tx_valid low in HS_DATA ends packet
//   tx_ready      : payload accept, high only in HS_DATA
//   time_pass     : single-cycle pulse from the timer
//   timer_enable  : timer run enable (low in first cycle of a timed state)
//   timer_reload  : reload value for the current timed state
//   lp_dp, lp_dn  : low-power line levels
//   hs_en,hs_data : HS driver enable and byte to the serializer
//   busy          : high whenever the lane is not IDLE
// -----------------------------------------------------------------------------
module dphy_hs_tx_sequencer
    import dphy_pkg::*;
#(
    parameter logic [5:0] T_LPX        = 6'd4,
    parameter logic [5:0] T_HS_PREPARE = 6'd5,
    parameter logic [5:0] T_HS_ZERO    = 6'd12,
    parameter logic [5:0] T_HS_TRAIL   = 6'd8,
    parameter logic [5:0] T_HS_EXIT    = 6'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       time_pass,
    output logic       timer_enable,
    output logic [5:0] timer_reload,
    output logic       lp_dp,
    output logic       lp_dn,
    output logic       hs_en,
    output logic [7:0] hs_data,
    output logic       busy
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       last_bit_q;
    logic       last_bit_d;
    logic [1:0] lp_level;

    // -------------------------------------------------------------------------
    // State and last_bit registers -- the only storage in this block.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= '{st: ST_IDLE, ph: PH_FIRST};
            last_bit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_bit_q <= last_bit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned -- that is what keeps this block free of latches.
    always_comb begin
        state_d    = state_q;
        last_bit_d = last_bit_q;

        case (state_q.st)
            ST_IDLE: begin
                if (hs_req) begin
                    state_d = '{st: ST_LP_RQST, ph: PH_FIRST};
                end
            end

            ST_HS_SYNC: begin
                // Trail polarity for an empty packet follows the sync byte.
                last_bit_d = SYNC_BYTE[7];
                state_d    = '{st: ST_HS_DATA, ph: PH_FIRST};
            end

            ST_HS_DATA: begin
                if (tx_valid) begin
                    last_bit_d = tx_data[7];
                end else begin
                    state_d = '{st: ST_HS_TRAIL, ph: PH_FIRST};
                end
            end

            default: begin
                // Timed states. Pulses seen while the timer is still held off
                // (PH_FIRST) are leftovers from the previous state's timer run.
                case (state_q.ph)
                    PH_FIRST: state_d.ph = PH_ARM;
                    PH_ARM: begin
                        if (time_pass) begin
                            state_d.ph = PH_RUN;
                        end
                    end
                    PH_RUN: begin
                        if (time_pass) begin
                            state_d = '{st: timed_successor(state_q.st), ph: PH_FIRST};
                        end
                    end
                    default: state_d = '{st: ST_IDLE, ph: PH_FIRST};
                endcase
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from state, last_bit and tx_data
    // -------------------------------------------------------------------------
    always_comb begin
        lp_level     = LP11;
        hs_en        = 1'b0;
        hs_data      = 8'h00;
        tx_ready     = 1'b0;
        timer_reload = 6'd0;

        case (state_q.st)
            ST_LP_RQST: begin
                lp_level     = LP01;
                timer_reload = T_LPX;
            end
            ST_LP_BRIDGE: begin
                lp_level     = LP00;
                timer_reload = T_HS_PREPARE;
            end
            ST_HS_ZERO: begin
                lp_level     = LP00;
                hs_en        = 1'b1;
                timer_reload = T_HS_ZERO;
            end
            ST_HS_SYNC: begin
                lp_level = LP00;
                hs_en    = 1'b1;
                hs_data  = SYNC_BYTE;
            end
            ST_HS_DATA: begin
                lp_level = LP00;
                hs_en    = 1'b1;
                tx_ready = 1'b1;
                hs_data  = tx_data;
            end
            ST_HS_TRAIL: begin
                // Trail holds the inverse of the last transmitted bit.
                lp_level     = LP00;
                hs_en        = 1'b1;
                hs_data      = {8{~last_bit_q}};
                timer_reload = T_HS_TRAIL;
            end
            ST_LP_EXIT: begin
                lp_level     = LP11;
                timer_reload = T_HS_EXIT;
            end
            default: begin
                lp_level = LP11;
            end
        endcase
    end

    assign {lp_dp, lp_dn} = lp_level;
    assign timer_enable   = is_timed(state_q.st) && (state_q.ph != PH_FIRST);
    assign busy           = (state_q.st != ST_IDLE);

endmodule
